// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC: IEEE-754 single angle in, single-precision sin or cos out.
// One micro-rotation per enabled cycle; start/done handshake with range rejection.
module cordic_sincos_iter #(
  parameter int unsigned W    = 22,
  parameter int unsigned ITER = 16
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic        n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        range_err
);

  localparam int unsigned FRAC = W - 2;
  localparam int unsigned CW   = 5;
  localparam int unsigned SH   = 30 - FRAC;
  localparam logic [32:0] RND  = 33'((64'(1) << SH) >> 1);

  function automatic real k_gain(input int unsigned iters);
    real k;
    k = 1.0;
    for (int unsigned i = 0; i < iters; i++) k = k / $sqrt(1.0 + 1.0 / (4.0 ** i));
    return k;
  endfunction

  localparam logic [W-1:0] K_FIX = W'($rtoi(k_gain(ITER) * (2.0 ** FRAC) + 0.5));

  // atan(2^-i) at 30 fractional bits; beyond i = 9 the value rounds to 2^(30-i)
  function automatic logic [31:0] atan_rom(input logic [CW-1:0] idx);
    case (idx)
      5'd0:    atan_rom = 32'h3243F6A9;
      5'd1:    atan_rom = 32'h1DAC6705;
      5'd2:    atan_rom = 32'h0FADBAFD;
      5'd3:    atan_rom = 32'h07F56EA7;
      5'd4:    atan_rom = 32'h03FEAB77;
      5'd5:    atan_rom = 32'h01FFD55C;
      5'd6:    atan_rom = 32'h00FFFAAB;
      5'd7:    atan_rom = 32'h007FFF55;
      5'd8:    atan_rom = 32'h003FFFEB;
      5'd9:    atan_rom = 32'h001FFFFD;
      default: atan_rom = 32'h40000000 >> idx;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_PACK} state_t;

  state_t               state_q, state_d;
  logic signed [W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mode_q, mode_d, rerr_q, rerr_d;
  logic                 done_q, done_d, range_err_q, range_err_d;
  logic [31:0]          result_q, result_d;

  logic [7:0]           in_exp;
  logic [23:0]          in_man;
  int                   in_sh;
  logic [63:0]          in_mag;
  logic signed [W-1:0]  in_fix;
  logic                 in_rerr;

  logic signed [W-1:0]  x_sh, y_sh, atan_w;
  logic [32:0]          atan_r;

  logic signed [W-1:0]  pk_v;
  logic [W-1:0]         pk_mag;
  int                   pk_p;
  logic [W+22:0]        pk_tmp;
  logic [31:0]          pk_word;

  // float_to_fixed and range check on the incoming angle
  always_comb begin
    in_exp  = dataa[30:23];
    in_man  = {1'b1, dataa[22:0]};
    in_sh   = int'(in_exp) - 150 + int'(FRAC);
    if (in_sh >= 0) in_mag = 64'(in_man) << 32'(in_sh);
    else            in_mag = 64'(in_man) >> 32'(-in_sh);
    in_fix  = W'(in_mag);
    if (dataa[31])      in_fix = -in_fix;
    if (in_exp == 8'h0) in_fix = '0;
    in_rerr = (dataa[30:0] > 31'h3FC90FDB) || (in_exp == 8'hFF);
  end

  always_comb begin
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_r = ({1'b0, atan_rom(cnt_q)} + RND) >> SH;
    atan_w = W'(atan_r);
  end

  // fixed_to_float of the selected coordinate, mantissa truncated
  always_comb begin
    pk_v   = mode_q ? y_q : x_q;
    pk_mag = pk_v[W-1] ? W'(-pk_v) : W'(pk_v);
    pk_p   = 0;
    for (int b = 0; b < int'(W); b++) if (pk_mag[b]) pk_p = b;
    pk_tmp = {pk_mag, 23'b0} << 32'(int'(W) - 1 - pk_p);
    if (pk_mag == '0) pk_word = 32'h0;
    else pk_word = {pk_v[W-1], 8'(127 + pk_p - int'(FRAC)), 23'(pk_tmp >> (W - 1))};
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)        state_q <= S_IDLE;
    else if (clk_en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ITER;
      S_ITER:  if (cnt_q == CW'(ITER - 1)) state_d = S_PACK;
      S_PACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    rerr_d      = rerr_q;
    done_d      = 1'b0;
    result_d    = result_q;
    range_err_d = range_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = n;
          x_d    = K_FIX;
          y_d    = '0;
          z_d    = in_rerr ? '0 : in_fix;
          cnt_d  = '0;
          rerr_d = in_rerr;
        end
      end
      S_ITER: begin
        if (!z_q[W-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_w;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_w;
        end
        if (cnt_q != CW'(ITER - 1)) cnt_d = cnt_q + CW'(1);
      end
      S_PACK: begin
        done_d      = 1'b1;
        result_d    = rerr_q ? 32'h7FC00000 : pk_word;
        range_err_d = rerr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      rerr_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 32'h0;
      range_err_q <= 1'b0;
    end else if (clk_en) begin
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      rerr_q      <= rerr_d;
      done_q      <= done_d;
      result_q    <= result_d;
      range_err_q <= range_err_d;
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Directed bench for cordic_sincos_iter: default build plus W=18/ITER=12 and W=32/ITER=28 builds.
module tb_cordic_sincos_iter;

  logic        clock, aclr, clk_en, start, n;
  logic [31:0] dataa;
  logic        done0, done1, done2;
  logic [31:0] result0, result1, result2;
  logic        range_err0, range_err1, range_err2;

  int checks = 0;
  int errors = 0;

  cordic_sincos_iter dut0 (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start), .n(n), .dataa(dataa),
    .done(done0), .result(result0), .range_err(range_err0));

  cordic_sincos_iter #(.W(18), .ITER(12)) dut1 (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start), .n(n), .dataa(dataa),
    .done(done1), .result(result1), .range_err(range_err1));

  cordic_sincos_iter #(.W(32), .ITER(28)) dut2 (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start), .n(n), .dataa(dataa),
    .done(done2), .result(result2), .range_err(range_err2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -v : v;
  endfunction

  // Accuracy bound plus one single-precision ulp at 1.0 for the truncating float pack
  function automatic real tol_for(input int iter, input int frac);
    int m;
    m = (iter < frac) ? iter : frac;
    return 2.0 ** (-(m - 2)) + 2.0 ** (-23);
  endfunction

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic run0(input logic mode, input logic [31:0] ang,
                      output int lat, output logic [31:0] res, output logic re);
    @(negedge clock);
    n = mode; dataa = ang; start = 1'b1;
    @(negedge clock);
    start = 1'b0; lat = -1; res = 32'h0; re = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done0 === 1'b1) begin
        lat = k; res = result0; re = range_err0;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    aclr = 1'b1; clk_en = 1'b1; start = 1'b0; n = 1'b0; dataa = 32'h0;
    repeat (2) @(negedge clock);
    checks++; if (done0 !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b want=0", done0); end
    checks++; if (result0 !== 32'h0)  begin errors++; $display("FAIL reset_result got=%h want=00000000", result0); end
    checks++; if (range_err0 !== 1'b0) begin errors++; $display("FAIL reset_range_err got=%b want=0", range_err0); end
    checks++; if ({done1, done2, result1, result2} !== 66'h0)
      begin errors++; $display("FAIL reset_sweep_dut got=%b%b %h %h want=all zero", done1, done2, result1, result2); end
    aclr = 1'b0;
  endtask

  task automatic test_cos0;
    int lat; logic [31:0] res; logic re; real e;
    run0(1'b0, 32'h00000000, lat, res, re);
    e = absr(f2r(res) - 1.0);
    checks++; if (lat !== 17) begin errors++; $display("FAIL cos0_latency got=%0d want=17", lat); end
    checks++; if (e > tol_for(16, 20)) begin errors++; $display("FAIL cos0_value got=%h (err %g) want~3F800000", res, e); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL cos0_range_err got=%b want=0", re); end
    @(negedge clock);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL cos0_done_width got=%b want=0", done0); end
  endtask

  task automatic test_sin_neg;
    int lat; logic [31:0] res; logic re; real e;
    run0(1'b1, 32'hBF000000, lat, res, re);
    e = absr(f2r(res) - (-0.479425538604203));
    checks++; if (e > tol_for(16, 20)) begin errors++; $display("FAIL sin_m05_value got=%h (err %g) want~BEF577xx", res, e); end
    checks++; if (res[31] !== 1'b1) begin errors++; $display("FAIL sin_m05_sign got=%b want=1", res[31]); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL sin_m05_range_err got=%b want=0", re); end
  endtask

  task automatic test_range_err;
    logic [31:0] angs [2];
    int lat; logic [31:0] res; logic re;
    angs = '{32'h40000000, 32'h7F800000};
    for (int i = 0; i < 2; i++) begin
      run0(1'b0, angs[i], lat, res, re);
      checks++; if (res !== 32'h7FC00000) begin errors++; $display("FAIL range_result[%0d] got=%h want=7FC00000", i, res); end
      checks++; if (re !== 1'b1) begin errors++; $display("FAIL range_flag[%0d] got=%b want=1", i, re); end
      checks++; if (lat !== 17) begin errors++; $display("FAIL range_latency[%0d] got=%0d want=17", i, lat); end
    end
  endtask

  task automatic test_stall;
    int lat_ref, lat; logic [31:0] res_ref, res; logic re; int extra;
    run0(1'b1, 32'h3F000000, lat_ref, res_ref, re);
    @(negedge clock);
    n = 1'b1; dataa = 32'h3F000000; start = 1'b1;
    @(negedge clock);
    start = 1'b0; lat = -1; res = 32'h0;
    for (int k = 0; k < 80; k++) begin
      if (k == 4)  clk_en = 1'b0;
      if (k == 9)  clk_en = 1'b1;
      if (k == 12) begin n = 1'b0; dataa = 32'h40000000; start = 1'b1; end
      if (k == 13) start = 1'b0;
      if (done0 === 1'b1) begin lat = k; res = result0; break; end
      @(negedge clock);
    end
    checks++; if (lat !== 22) begin errors++; $display("FAIL stall_latency got=%0d want=22", lat); end
    checks++; if (res !== res_ref) begin errors++; $display("FAIL stall_result got=%h want=%h", res, res_ref); end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done0 === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL stall_second_done got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] res; logic re; real e;
    @(negedge clock);
    n = 1'b0; dataa = 32'h00000000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #2 aclr = 1'b1;
    #1;
    checks++; if (done0 !== 1'b0)      begin errors++; $display("FAIL midrst_done got=%b want=0", done0); end
    checks++; if (result0 !== 32'h0)   begin errors++; $display("FAIL midrst_result got=%h want=00000000", result0); end
    checks++; if (range_err0 !== 1'b0) begin errors++; $display("FAIL midrst_range_err got=%b want=0", range_err0); end
    @(negedge clock);
    aclr = 1'b0;
    run0(1'b0, 32'h00000000, lat, res, re);
    e = absr(f2r(res) - 1.0);
    checks++; if (lat !== 17) begin errors++; $display("FAIL midrst_restart_latency got=%0d want=17", lat); end
    checks++; if (e > tol_for(16, 20)) begin errors++; $display("FAIL midrst_restart_value got=%h (err %g) want~3F800000", res, e); end
  endtask

  task automatic test_sweep;
    logic [31:0] angs [5];
    real ecos [5];
    real esin [5];
    logic got1, got2; logic [31:0] r1, r2; real ex, e1, e2;
    angs = '{32'h3FC90FDB, 32'hBFC90FDB, 32'h3F800000, 32'hBF800000, 32'h358637BD};
    ecos = '{-4.371139e-8, -4.371139e-8, 0.5403023058681398, 0.5403023058681398, 1.0};
    esin = '{1.0, -1.0, 0.8414709848078965, -0.8414709848078965, 1.0e-6};
    repeat (40) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      for (int m = 0; m < 2; m++) begin
        n = m[0]; dataa = angs[i]; start = 1'b1;
        @(negedge clock);
        start = 1'b0; got1 = 1'b0; got2 = 1'b0; r1 = 32'h0; r2 = 32'h0;
        for (int k = 0; k < 60 && !(got1 && got2); k++) begin
          if (done1 === 1'b1) begin got1 = 1'b1; r1 = result1; end
          if (done2 === 1'b1) begin got2 = 1'b1; r2 = result2; end
          @(negedge clock);
        end
        ex = (m == 0) ? ecos[i] : esin[i];
        e1 = absr(f2r(r1) - ex);
        e2 = absr(f2r(r2) - ex);
        checks++;
        if (!got1 || e1 > tol_for(12, 16))
          begin errors++; $display("FAIL sweep_w18[%0d,%0d] got=%h done=%b (err %g) want~%g", i, m, r1, got1, e1, ex); end
        checks++;
        if (!got2 || e2 > tol_for(28, 30))
          begin errors++; $display("FAIL sweep_w32[%0d,%0d] got=%h done=%b (err %g) want~%g", i, m, r2, got2, e2, ex); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_cos0;
    test_sin_neg;
    test_range_err;
    test_reset_mid;
    test_stall;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
